// File: rtl/conv_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// conv_pkg : shared types and float16 arithmetic for the conv engine
// Rev 1.0
// ------------------------------------------------------------------
package conv_pkg;

  localparam logic [15:0] FP16_ONE  = 16'h3C00;
  localparam logic [15:0] FP16_QNAN = 16'h7E00;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DRAIN = 2'd2, OUTPUT = 2'd3} state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Shared RNE rounding, overflow-to-inf and flush-to-zero of a normalised result.
  function automatic logic [15:0] fp16_round(input logic s, input int e_in,
                                             input logic [10:0] mant, input logic g,
                                             input logic st);
    logic [11:0] m;
    int          e;
    m = {1'b0, mant};
    e = e_in;
    if (g && (st || m[0])) m = m + 12'd1;
    if (m[11]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 31) return {s, 15'h7C00};
    if (e <= 0) return {s, 15'h0000};
    return {s, e[4:0], m[9:0]};
  endfunction

  function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
    logic        s, a_z, b_z, a_inf, b_inf, a_nan, b_nan;
    logic [21:0] p;
    int          e;
    s     = a[15] ^ b[15];
    a_z   = (a[14:10] == 5'd0);
    b_z   = (b[14:10] == 5'd0);
    a_inf = (a[14:10] == 5'h1f) && (a[9:0] == 10'd0);
    b_inf = (b[14:10] == 5'h1f) && (b[9:0] == 10'd0);
    a_nan = (a[14:10] == 5'h1f) && (a[9:0] != 10'd0);
    b_nan = (b[14:10] == 5'h1f) && (b[9:0] != 10'd0);
    if (a_nan || b_nan || (a_inf && b_z) || (b_inf && a_z)) return FP16_QNAN;
    if (a_inf || b_inf) return {s, 15'h7C00};
    if (a_z || b_z) return {s, 15'h0000};
    p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p[21]) return fp16_round(s, e + 1, p[21:11], p[10], |p[9:0]);
    return fp16_round(s, e, p[20:10], p[9], |p[8:0]);
  endfunction

  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic        a_z, b_z, a_inf, b_inf, a_nan, b_nan, sb;
    logic [15:0] x, y;
    logic [23:0] xa, xb;
    logic [24:0] sum, norm;
    int          d, e, msb;
    a_z   = (a[14:10] == 5'd0);
    b_z   = (b[14:10] == 5'd0);
    a_inf = (a[14:10] == 5'h1f) && (a[9:0] == 10'd0);
    b_inf = (b[14:10] == 5'h1f) && (b[9:0] == 10'd0);
    a_nan = (a[14:10] == 5'h1f) && (a[9:0] != 10'd0);
    b_nan = (b[14:10] == 5'h1f) && (b[9:0] != 10'd0);
    if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) return FP16_QNAN;
    if (a_inf) return {a[15], 15'h7C00};
    if (b_inf) return {b[15], 15'h7C00};
    if (a_z && b_z) return {a[15] & b[15], 15'h0000};
    if (a_z) return b;
    if (b_z) return a;
    if (a[14:0] >= b[14:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    d  = int'(x[14:10]) - int'(y[14:10]);
    xa = {1'b1, x[9:0], 13'h0};
    xb = {1'b1, y[9:0], 13'h0};
    // Bits shifted out of the smaller operand collapse into a sticky LSB.
    if (d >= 24) begin
      xb = 24'h0;
      sb = 1'b1;
    end else begin
      sb = |(xb & ((24'h1 << d) - 24'h1));
      xb = xb >> d;
    end
    xb[0] = xb[0] | sb;
    if (x[15] == y[15]) sum = {1'b0, xa} + {1'b0, xb};
    else                sum = {1'b0, xa} - {1'b0, xb};
    if (sum == 25'd0) return 16'h0000;
    msb = 0;
    for (int i = 0; i < 25; i++) if (sum[i]) msb = i;
    e    = int'(x[14:10]) + msb - 23;
    norm = sum << (24 - msb);
    return fp16_round(x[15], e, norm[24:14], norm[13], |norm[12:0]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp16_mac_lane.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// fp16_mac_lane : one float16 multiply-accumulate lane, MAC_LAT deep
// Rev 1.0
// ------------------------------------------------------------------
module fp16_mac_lane
  import conv_pkg::*;
#(
  parameter int MAC_LAT = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        seed_load_i,
  input  logic [15:0] seed_i,
  input  logic        issue_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] acc_o
);

  logic [15:0] w_prod;
  logic [15:0] w_add_op;
  logic        w_add_vld;
  logic [15:0] acc_q;

  assign w_prod = fp16_mul(a_i, b_i);

  // Products are delayed MAC_LAT-1 stages; the add closes in the final stage so
  // back-to-back beats still accumulate strictly in issue order.
  generate
    if (MAC_LAT == 1) begin : g_direct
      assign w_add_op  = w_prod;
      assign w_add_vld = issue_i;
    end else begin : g_pipe
      logic [15:0]        prod_q [MAC_LAT-1];
      logic [MAC_LAT-2:0] vld_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          vld_q <= '0;
          for (int i = 0; i < MAC_LAT - 1; i++) prod_q[i] <= '0;
        end else begin
          prod_q[0] <= w_prod;
          vld_q[0]  <= issue_i;
          for (int i = 1; i < MAC_LAT - 1; i++) begin
            prod_q[i] <= prod_q[i-1];
            vld_q[i]  <= vld_q[i-1];
          end
        end
      end

      assign w_add_op  = prod_q[MAC_LAT-2];
      assign w_add_vld = vld_q[MAC_LAT-2];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)          acc_q <= '0;
    else if (seed_load_i) acc_q <= seed_i;
    else if (w_add_vld)   acc_q <= fp16_add(acc_q, w_add_op);
  end

  assign acc_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/conv_para_scale_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// conv_para_scale_engine : float16 MAC array with job FSM and handshakes
// Rev 1.0
// ------------------------------------------------------------------
module conv_para_scale_engine
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int PARA_X          = 4,
  parameter int PARA_Y          = 4,
  parameter int KERNEL_SIZE_MAX = 11,
  parameter int KS_WIDTH        = 6,
  parameter int MAC_LAT         = 3
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 start_i,
  input  logic [KS_WIDTH-1:0]                  kernel_size_i,
  input  logic                                 acc_mode_i,
  input  logic [PARA_X*PARA_Y*DATA_WIDTH-1:0]  psum_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [PARA_X*PARA_Y*DATA_WIDTH-1:0]  in_data_i,
  input  logic [DATA_WIDTH-1:0]                weight_i,
  output logic                                 result_valid_o,
  input  logic                                 result_ready_i,
  output logic [PARA_X*PARA_Y*DATA_WIDTH-1:0]  result_data_o,
  output logic                                 busy_o,
  output logic                                 cfg_err_o
);

  localparam int LANES  = PARA_X * PARA_Y;
  localparam int KK_W   = 2 * KS_WIDTH;
  localparam int BEAT_W = clog2(KERNEL_SIZE_MAX * KERNEL_SIZE_MAX + 1);
  localparam int DRN_W  = clog2(MAC_LAT + 1);

  state_e                        state_q, state_d;
  logic [KS_WIDTH-1:0]           k_q, k_d;
  logic [BEAT_W-1:0]             beat_q, beat_d;
  logic [DRN_W-1:0]              drain_q, drain_d;
  logic                          cfg_err_q, cfg_err_d;
  logic [LANES*DATA_WIDTH-1:0]   result_q;

  logic [KK_W-1:0]               w_kk;
  logic                          w_ks_ok, w_start_window, w_accept, w_issue;
  logic                          w_last_beat, w_load_result;
  logic [LANES*DATA_WIDTH-1:0]   w_acc;

  assign w_kk           = KK_W'(k_q) * KK_W'(k_q);
  assign w_ks_ok        = (kernel_size_i != '0) && (kernel_size_i <= KS_WIDTH'(KERNEL_SIZE_MAX));
  assign w_start_window = (state_q == IDLE) || ((state_q == OUTPUT) && result_ready_i);
  assign w_accept       = start_i && w_ks_ok && w_start_window;
  assign w_issue        = (state_q == ACCUM) && in_valid_i;
  assign w_last_beat    = (KK_W'(beat_q) + KK_W'(1)) == w_kk;

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    beat_d        = beat_q;
    drain_d       = drain_q;
    w_load_result = 1'b0;
    cfg_err_d     = start_i && !w_ks_ok && w_start_window;
    case (state_q)
      ACCUM: begin
        if (w_issue) begin
          if (w_last_beat) begin
            state_d = DRAIN;
            beat_d  = '0;
            drain_d = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (drain_q == DRN_W'(MAC_LAT - 1)) begin
          state_d       = OUTPUT;
          w_load_result = 1'b1;
        end else begin
          drain_d = drain_q + DRN_W'(1);
        end
      end
      OUTPUT:  if (result_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A legal start in IDLE, or alongside an OUTPUT handshake, overrides the above.
    if (w_accept) begin
      state_d = ACCUM;
      k_d     = kernel_size_i;
      beat_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      k_q       <= '0;
      beat_q    <= '0;
      drain_q   <= '0;
      cfg_err_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      beat_q    <= beat_d;
      drain_q   <= drain_d;
      cfg_err_q <= cfg_err_d;
      if (w_load_result) result_q <= w_acc;
    end
  end

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      fp16_mac_lane #(
        .MAC_LAT (MAC_LAT)
      ) u_lane (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .seed_load_i (w_accept),
        .seed_i      (acc_mode_i ? psum_i[i*DATA_WIDTH +: DATA_WIDTH] : '0),
        .issue_i     (w_issue),
        .a_i         (in_data_i[i*DATA_WIDTH +: DATA_WIDTH]),
        .b_i         (weight_i),
        .acc_o       (w_acc[i*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

  assign in_ready_o     = (state_q == ACCUM);
  assign result_valid_o = (state_q == OUTPUT);
  assign busy_o         = (state_q != IDLE);
  assign cfg_err_o      = cfg_err_q;
  assign result_data_o  = result_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_para_scale_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// tb_conv_para_scale_engine : directed self-checking bench
// Rev 1.0
// ------------------------------------------------------------------
module tb_conv_para_scale_engine;
  import conv_pkg::*;

  localparam int LANES   = 16;
  localparam int MAC_LAT = 3;
  localparam int W       = LANES * 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [5:0]   ks = '0;
  logic         acc_mode = 1'b0;
  logic [W-1:0] psum = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [15:0]  weight = '0;
  logic         result_valid;
  logic         result_ready = 1'b0;
  logic [W-1:0] result_data;
  logic         busy;
  logic         cfg_err;

  int           n_assert = 0;
  int           n_fail = 0;
  int           beats = 0;
  int           n, b0, acc_cnt;
  logic         seen, v;
  logic [W-1:0] expv;

  always #5 clk = ~clk;

  always @(negedge clk) if (in_valid && in_ready) beats <= beats + 1;

  conv_para_scale_engine #(
    .DATA_WIDTH      (16),
    .PARA_X          (4),
    .PARA_Y          (4),
    .KERNEL_SIZE_MAX (11),
    .KS_WIDTH        (6),
    .MAC_LAT         (MAC_LAT)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .kernel_size_i  (ks),
    .acc_mode_i     (acc_mode),
    .psum_i         (psum),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_data_i      (in_data),
    .weight_i       (weight),
    .result_valid_o (result_valid),
    .result_ready_i (result_ready),
    .result_data_o  (result_data),
    .busy_o         (busy),
    .cfg_err_o      (cfg_err)
  );

  function automatic logic [W-1:0] rep(input logic [15:0] x);
    return {LANES{x}};
  endfunction

  task automatic chkd(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_result(output int cnt);
    cnt = 0;
    while (!result_valid && cnt < 300) begin
      tick();
      cnt++;
    end
    chkb("result_valid_seen", result_valid, 1'b1);
  endtask

  task automatic handshake();
    in_valid     = 1'b0;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chkb("rst_in_ready", in_ready, 1'b0);
    chkb("rst_result_valid", result_valid, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_cfg_err", cfg_err, 1'b0);
    chkd("rst_result_data", result_data, '0);
    rst_n = 1'b1;
    tick();
    chkb("idle_busy", busy, 1'b0);

    // K=3, acc_mode=0: nine 1.0*1.0 beats -> 9.0 with exact latency
    in_data = rep(FP16_ONE); weight = FP16_ONE; acc_mode = 1'b0; in_valid = 1'b1;
    start = 1'b1; ks = 6'd3; b0 = beats;
    tick();
    start = 1'b0;
    chkb("t1_busy", busy, 1'b1);
    chkb("t1_in_ready", in_ready, 1'b1);
    wait_result(n);
    chki("t1_latency", 1 + n, 1 + 9 + MAC_LAT);
    chkd("t1_data", result_data, rep(16'h4880));
    chki("t1_beats", beats - b0, 9);
    handshake();
    chkb("t1_idle_busy", busy, 1'b0);
    chkb("t1_idle_valid", result_valid, 1'b0);

    // K=3, acc_mode=1 seeded with 2.0 -> 11.0; psum changed after latch
    acc_mode = 1'b1; psum = rep(16'h4000); in_valid = 1'b1; start = 1'b1; ks = 6'd3;
    tick();
    start = 1'b0; psum = rep(16'h5000);
    wait_result(n);
    chkd("t2_data", result_data, rep(16'h4980));
    handshake();

    // K=2, 2.0*0.5 with in_valid toggling -> 4.0
    acc_mode = 1'b0; in_data = rep(16'h4000); weight = 16'h3800;
    start = 1'b1; ks = 6'd2; in_valid = 1'b0;
    tick();
    start = 1'b0; b0 = beats; acc_cnt = 0; seen = 1'b0; v = 1'b1;
    for (int c = 0; c < 60 && !result_valid; c++) begin
      in_valid = v;
      if (in_valid && in_ready) acc_cnt++;
      tick();
      if (acc_cnt == 4 && !seen) begin
        seen = 1'b1;
        chkb("t3_ready_drop", in_ready, 1'b0);
      end
      v = !v;
    end
    chki("t3_accepted", acc_cnt, 4);
    chki("t3_beats", beats - b0, 4);
    chkb("t3_valid", result_valid, 1'b1);
    chkd("t3_data", result_data, rep(16'h4400));
    handshake();

    // Illegal kernel sizes 0 and 12
    start = 1'b1; ks = 6'd0;
    tick();
    start = 1'b0;
    chkb("t4_k0_cfg_err", cfg_err, 1'b1);
    chkb("t4_k0_busy", busy, 1'b0);
    chkb("t4_k0_in_ready", in_ready, 1'b0);
    tick();
    chkb("t4_k0_cfg_err_pulse", cfg_err, 1'b0);
    start = 1'b1; ks = 6'd12;
    tick();
    start = 1'b0;
    chkb("t4_k12_cfg_err", cfg_err, 1'b1);
    chkb("t4_k12_busy", busy, 1'b0);
    chkb("t4_k12_in_ready", in_ready, 1'b0);
    tick();
    chkb("t4_k12_cfg_err_pulse", cfg_err, 1'b0);

    // K=11 upper bound: 121 * 1.0 -> 121.0
    in_data = rep(FP16_ONE); weight = FP16_ONE; in_valid = 1'b1; start = 1'b1; ks = 6'd11;
    tick();
    start = 1'b0;
    chkb("t4_k11_cfg_err", cfg_err, 1'b0);
    wait_result(n);
    chki("t4_k11_latency", 1 + n, 1 + 121 + MAC_LAT);
    chkd("t4_k11_data", result_data, rep(16'h5790));
    handshake();

    // OUTPUT backpressure, then handshake together with a new start
    in_data = rep(16'h4400); weight = FP16_ONE; in_valid = 1'b1; start = 1'b1; ks = 6'd1;
    tick();
    start = 1'b0;
    wait_result(n);
    start = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chkb("t5_hold_valid", result_valid, 1'b1);
      chkb("t5_hold_in_ready", in_ready, 1'b0);
      chkd("t5_hold_data", result_data, rep(16'h4400));
    end
    for (int i = 0; i < LANES; i++) begin
      in_data[i*16 +: 16] = 16'h4200 + 16'(i);
      expv[i*16 +: 16]    = 16'h4200 + 16'(i);
    end
    result_ready = 1'b1;
    tick();
    start = 1'b0; result_ready = 1'b0;
    chkb("t5_new_in_ready", in_ready, 1'b1);
    chkb("t5_new_valid", result_valid, 1'b0);
    wait_result(n);
    chkd("t5_new_data", result_data, expv);
    handshake();

    // Rounding and special values, one lane each (weight 1.0, K=1, seeded)
    psum = '0; in_data = '0;
    psum[0*16 +: 16] = 16'h3C00; in_data[0*16 +: 16] = 16'h1000;
    psum[1*16 +: 16] = 16'h3C01; in_data[1*16 +: 16] = 16'h1000;
    psum[2*16 +: 16] = 16'h7BFF; in_data[2*16 +: 16] = 16'h7BFF;
    psum[3*16 +: 16] = 16'hFC00; in_data[3*16 +: 16] = 16'h7C00;
    psum[4*16 +: 16] = 16'h0200; in_data[4*16 +: 16] = 16'h3C00;
    psum[5*16 +: 16] = 16'h3C00; in_data[5*16 +: 16] = 16'hBC00;
    expv = '0;
    expv[0*16 +: 16] = 16'h3C00;
    expv[1*16 +: 16] = 16'h3C02;
    expv[2*16 +: 16] = 16'h7C00;
    expv[3*16 +: 16] = FP16_QNAN;
    expv[4*16 +: 16] = 16'h3C00;
    expv[5*16 +: 16] = 16'h0000;
    acc_mode = 1'b1; weight = FP16_ONE; in_valid = 1'b1; start = 1'b1; ks = 6'd1;
    tick();
    start = 1'b0;
    wait_result(n);
    chkd("t6_round_special", result_data, expv);
    handshake();

    // Reset after 5 of 9 beats, then a clean K=1 job
    acc_mode = 1'b1; psum = rep(16'h4000); in_data = rep(FP16_ONE); weight = FP16_ONE;
    in_valid = 1'b1; start = 1'b1; ks = 6'd3;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chkb("t7_rst_in_ready", in_ready, 1'b0);
    chkb("t7_rst_busy", busy, 1'b0);
    chkb("t7_rst_valid", result_valid, 1'b0);
    chkb("t7_rst_cfg_err", cfg_err, 1'b0);
    chkd("t7_rst_data", result_data, '0);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    acc_mode = 1'b0; psum = '0; in_valid = 1'b1; start = 1'b1; ks = 6'd1;
    tick();
    start = 1'b0;
    wait_result(n);
    chkd("t7_after_reset_data", result_data, rep(FP16_ONE));
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
